dac_adc_sequencer: RTL and testbench
====================================

// Module: dac_adc_sequencer
// PURPOSE
//  Sequences the analog front end for signal_ctrl: accepts DAC update requests from four channels.
//  Serves them round-robin through one shared DAC8411 serializer start/busy handshake.
//  Once all pending updates are written and a settle time has elapsed, it triggers one ADS8860 conversion.
//  Returns the sample to the requester side, so every ADC reading follows a complete, settled DAC state.
// PARAMETERS
//  SETTLE_CYCLES   200  clk cycles from last DAC busy fall to adc_start (0 = trigger next cycle)
//  BUSY_TIMEOUT    16   max cycles to wait for dac_busy to rise after dac_start before treating write as done
//  ADC_TIMEOUT     4096 max cycles in ADC_WAIT before abandoning conversion
// PORTS
//  clk           in   1   system clock
//  RST_N         in   1   synchronous active-low reset
//  req_valid     in   4   per-channel update request, channel i = bit i
//  req_data      in   64  packed codes, ch i at [16*i+15:16*i]
//  req_ready     out  4   channel i holding register empty
//  dac_start     out  1   one-cycle pulse: serializer loads dac_word for dac_sel
//  dac_sel       out  2   channel being written (0..3)
//  dac_word      out  16  code being written, stable from dac_start until busy falls
//  dac_busy      in   1   serializer busy
//  adc_start     out  1   one-cycle conversion trigger
//  adc_data      in   16  conversion result
//  adc_done      in   1   one-cycle pulse, adc_data valid
//  sample_data   out  16  last captured ADC result
//  sample_valid  out  1   one-cycle pulse with new sample_data
//  seq_idle      out  1   FSM in IDLE and no channel pending
// BEHAVIOUR
//  Reset (RST_N=0 at clk edge):
//   - all pending flags cleared, FSM->IDLE, RR pointer=0
//   - req_ready=4'hF; dac_start, adc_start and sample_valid = 0
//   - dac_sel=0, dac_word=0, sample_data=0, seq_idle=1
//   - a reset mid-operation abandons the current sequence; no further start pulses follow
//  Accept:
//   - req_valid[i]&req_ready[i] latches the code into hold[i], sets pending[i], and drops req_ready[i] next cycle
//  Channel pick:
//   - round-robin: lowest-index pending channel at or after (last_served+1) mod 4, wrapping 3->0
//  States:
//   - IDLE:      any pending -> ISSUE
//   - ISSUE:     load dac_sel/dac_word from the picked hold reg; pulse dac_start; clear pending[sel]
//                (req_ready[sel]=1 next cycle, so a new code can be accepted while it is written); -> WAIT_HI
//   - WAIT_HI:   dac_busy=1 -> WAIT_LO; BUSY_TIMEOUT cycles without busy -> WAIT_LO exit path taken directly
//   - WAIT_LO:   dac_busy=0 -> ISSUE if any pending, else -> SETTLE (counter loaded)
//   - SETTLE:    count SETTLE_CYCLES; a new request arriving during SETTLE -> ISSUE (settle restarts afterwards);
//                on expiry -> ADC_TRIG
//   - ADC_TRIG:  pulse adc_start for 1 cycle -> ADC_WAIT
//   - ADC_WAIT:  adc_done -> capture adc_data into sample_data; sample_valid=1 the following cycle; -> IDLE
//                ADC_TIMEOUT expiry -> IDLE with no sample_valid
//  Requests in ADC_TRIG/ADC_WAIT:
//   - accepted into hold regs but not issued until IDLE (never disturb DAC during conversion)
//  Same-cycle events:
//   - accept on channel i in the same cycle as ISSUE of channel i is impossible (ready low while pending)
//   - accept in the cycle after ISSUE sets pending again and is served in a later round
//  Latency:
//   - single request from IDLE: dac_start 2 cycles after acceptance (accept->IDLE->ISSUE)
// TESTING
//  1. Single request ch2=16'h8000, busy high 34 cycles -> dac_sel=2, word 8000, one dac_start;
//     adc_start exactly SETTLE_CYCLES+1 cycles after busy falls; adc_done with 16'h1234 -> sample_data=1234, one sample_valid pulse
//  2. All four valid same cycle -> dac writes in order 0,1,2,3; only one adc_start after ch3 completes
//  3. Fairness: ch0 re-requests immediately after every issue while ch1,ch3 pending -> order 0,1,3,0 (wrap), no starvation
//  4. dac_busy never rises -> after BUSY_TIMEOUT cycles FSM advances; sequence still ends with adc_start
//  5. Request ch1 during SETTLE at count 100 -> ch1 written, settle restarts full SETTLE_CYCLES before adc_start
//  6. RST_N low during ADC_WAIT, then adc_done arrives -> no sample_valid; outputs at reset values; seq_idle=1

Source files
------------

// File: rtl/dac_adc_sequencer.sv
// Round-robin DAC update sequencer for four channels. Once every pending code
// is written and the analog path has settled, it triggers one ADC conversion.
module dac_adc_sequencer #(
  parameter int SETTLE_CYCLES = 200,
  parameter int BUSY_TIMEOUT  = 16,
  parameter int ADC_TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic [3:0]  req_valid,
  input  logic [63:0] req_data,
  output logic [3:0]  req_ready,
  output logic        dac_start,
  output logic [1:0]  dac_sel,
  output logic [15:0] dac_word,
  input  logic        dac_busy,
  output logic        adc_start,
  input  logic [15:0] adc_data,
  input  logic        adc_done,
  output logic [15:0] sample_data,
  output logic        sample_valid,
  output logic        seq_idle
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_HI, WAIT_LO, SETTLE, ADC_TRIG, ADC_WAIT
  } state_t;

  localparam int TMAX_A = (SETTLE_CYCLES > BUSY_TIMEOUT) ? SETTLE_CYCLES : BUSY_TIMEOUT;
  localparam int TMAX   = (TMAX_A > ADC_TIMEOUT) ? TMAX_A : ADC_TIMEOUT;
  localparam int TW     = $clog2(TMAX + 1);

  state_t        state, state_d, after_write;
  logic [3:0]    pending, accept, issue_clr;
  logic [15:0]   hold [4];
  logic [1:0]    rr_ptr, pick;
  logic [TW-1:0] timer;
  logic          any_pending, timer_run;

  assign accept      = req_valid & ~pending;
  assign any_pending = |pending;
  assign req_ready   = ~pending;
  assign seq_idle    = (state == IDLE) && !any_pending;
  assign timer_run   = (state == WAIT_HI) || (state == SETTLE) || (state == ADC_WAIT);

  // Walk down from the farthest offset so the nearest pending channel wins.
  always_comb begin
    pick = rr_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (pending[rr_ptr + 2'(k)]) pick = rr_ptr + 2'(k);
    end
  end

  // NOTE: every always_comb output gets a default before any branch so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    issue_clr   = '0;
    after_write = any_pending ? ISSUE : ((SETTLE_CYCLES == 0) ? ADC_TRIG : SETTLE);
    state_d     = state;
    if (state == ISSUE) issue_clr = 4'b0001 << dac_sel;
    unique case (state)
      IDLE:     if (any_pending) state_d = ISSUE;
      ISSUE:    state_d = WAIT_HI;
      WAIT_HI: begin
        if (dac_busy)                             state_d = WAIT_LO;
        else if (timer == TW'(BUSY_TIMEOUT - 1)) state_d = after_write;
      end
      WAIT_LO:  if (!dac_busy) state_d = after_write;
      SETTLE: begin
        // A late request must be written before converting; settle reruns after it.
        if (any_pending)                          state_d = ISSUE;
        else if (timer == TW'(SETTLE_CYCLES - 1)) state_d = ADC_TRIG;
      end
      ADC_TRIG: state_d = ADC_WAIT;
      ADC_WAIT: if (adc_done || timer == TW'(ADC_TIMEOUT - 1)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      state        <= IDLE;
      pending      <= '0;
      rr_ptr       <= '0;
      timer        <= '0;
      dac_sel      <= '0;
      dac_word     <= '0;
      dac_start    <= 1'b0;
      adc_start    <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_d;
      pending      <= (pending & ~issue_clr) | accept;
      timer        <= (state_d != state || !timer_run) ? '0 : timer + TW'(1);
      dac_start    <= (state_d == ISSUE);
      adc_start    <= (state_d == ADC_TRIG);
      sample_valid <= (state == ADC_WAIT) && adc_done;
      // The word is captured on entry to ISSUE and held until the next issue.
      if (state_d == ISSUE) begin
        dac_sel  <= pick;
        dac_word <= hold[pick];
      end
      if (state == ISSUE) rr_ptr <= dac_sel + 2'd1;
      if (state == ADC_WAIT && adc_done) sample_data <= adc_data;
    end
  end

  // NOTE: the holding registers carry no reset; a code is only ever read
  // while its pending flag is set, and that flag is reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (accept[i]) hold[i] <= req_data[16*i +: 16];
    end
  end

endmodule

// File: tb/tb_dac_adc_sequencer.sv
// Self-checking bench: serializer and ADC behavioural models plus a set-based
// round-robin reference that predicts write order, settle timing and samples.
module tb_dac_adc_sequencer;

  localparam int SETTLE = 200;
  localparam int BTO    = 16;
  localparam int ATO    = 4096;

  logic        clk = 1'b0;
  logic        RST_N;
  logic [3:0]  req_valid, req_ready;
  logic [63:0] req_data;
  logic        dac_start, dac_busy, adc_start, adc_done, sample_valid, seq_idle;
  logic [1:0]  dac_sel;
  logic [15:0] dac_word, adc_data, sample_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_adc_sequencer #(.SETTLE_CYCLES(SETTLE), .BUSY_TIMEOUT(BTO), .ADC_TIMEOUT(ATO)) dut (
    .clk(clk), .RST_N(RST_N), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .dac_start(dac_start), .dac_sel(dac_sel), .dac_word(dac_word),
    .dac_busy(dac_busy), .adc_start(adc_start), .adc_data(adc_data), .adc_done(adc_done),
    .sample_data(sample_data), .sample_valid(sample_valid), .seq_idle(seq_idle)
  );

  // Environment knobs
  bit          ser_dead = 1'b0;
  int          ser_delay = 1, ser_len = 10;
  bit          adc_en = 1'b1;
  int          adc_lat = 5;
  logic [15:0] adc_next = 16'h0;
  int          fall_cyc = 0, fall_cnt = 0, done_cyc = 0;

  // Observations
  int          wr_sel_q[$];
  logic [15:0] wr_word_q[$];
  int          wr_cyc_q[$];
  int          adc_cnt = 0, adc_cyc = 0, smp_cnt = 0, smp_cyc = 0;
  logic [15:0] smp_val = '0;

  // Reference model
  logic [3:0]  m_pend = '0;
  int          m_ptr = 0;
  logic [15:0] m_code[4];
  logic [15:0] rc[2];
  int          exp_sel_q[$];
  logic [15:0] exp_word_q[$];

  logic [15:0] code[4];
  int          acc_cyc = 0, adc_base = 0, smp_base = 0;

  // Serializer: busy rises ser_delay cycles after dac_start and lasts ser_len cycles.
  initial begin
    dac_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (dac_start && !ser_dead) begin
        repeat (ser_delay) begin @(posedge clk); #1; end
        dac_busy = 1'b1;
        repeat (ser_len) begin @(posedge clk); #1; end
        dac_busy = 1'b0;
        fall_cyc = cyc;
        fall_cnt++;
      end
    end
  end

  // ADC: one-cycle done pulse adc_lat cycles after adc_start.
  initial begin
    adc_done = 1'b0;
    adc_data = '0;
    forever begin
      @(posedge clk); #1;
      if (adc_start && adc_en) begin
        repeat (adc_lat) begin @(posedge clk); #1; end
        adc_data = adc_next;
        adc_done = 1'b1;
        done_cyc = cyc;
        @(posedge clk); #1;
        adc_done = 1'b0;
        adc_data = 16'($urandom);
      end
    end
  end

  always @(negedge clk) begin
    if (dac_start) begin
      wr_sel_q.push_back(int'(dac_sel));
      wr_word_q.push_back(dac_word);
      wr_cyc_q.push_back(cyc);
    end
    if (adc_start) begin
      adc_cnt++;
      adc_cyc = cyc;
    end
    if (sample_valid) begin
      smp_cnt++;
      smp_cyc = cyc;
      smp_val = sample_data;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_req(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) req_data[16*i +: 16] = code[i];
    req_valid = mask;
    acc_cyc   = cyc;
    tick();
    req_valid = '0;
  endtask

  task automatic model_accept(input logic [3:0] mask);
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) begin
        m_pend[i] = 1'b1;
        m_code[i] = code[i];
      end
    end
  endtask

  // Serve everything pending; channel 0 re-requests after its first `rereq` services.
  task automatic model_serve(input int rereq);
    int used = 0;
    int c;
    while (m_pend != 0) begin
      c = -1;
      for (int k = 0; k < 4; k++) begin
        if (c < 0 && m_pend[(m_ptr + k) % 4]) c = (m_ptr + k) % 4;
      end
      exp_sel_q.push_back(c);
      exp_word_q.push_back(m_code[c]);
      m_pend[c] = 1'b0;
      m_ptr = (c + 1) % 4;
      if (c == 0 && used < rereq) begin
        m_pend[0] = 1'b1;
        m_code[0] = rc[used];
        used++;
      end
    end
  endtask

  task automatic begin_round();
    wr_sel_q.delete();
    wr_word_q.delete();
    wr_cyc_q.delete();
    exp_sel_q.delete();
    exp_word_q.delete();
    adc_base = adc_cnt;
    smp_base = smp_cnt;
  endtask

  task automatic wait_sample(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (smp_cnt != smp_base) ok = 1'b1;
    end
    check({tag, "_sample_seen"}, 32'(ok), 32'd1);
    repeat (5) tick();
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      tick();
      if (seq_idle) ok = 1'b1;
    end
    check({tag, "_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, 32'(wr_sel_q.size()), 32'(exp_sel_q.size()));
    for (int i = 0; i < exp_sel_q.size() && i < wr_sel_q.size(); i++) begin
      check($sformatf("%s_sel%0d", tag, i), 32'(wr_sel_q[i]), 32'(exp_sel_q[i]));
      check($sformatf("%s_word%0d", tag, i), 32'(wr_word_q[i]), 32'(exp_word_q[i]));
    end
  endtask

  task automatic check_conv(input string tag, input int ref_cyc, input int gap);
    check({tag, "_nadc"}, 32'(adc_cnt - adc_base), 32'd1);
    check({tag, "_adc_gap"}, 32'(adc_cyc - ref_cyc), 32'(gap));
    check({tag, "_nsmp"}, 32'(smp_cnt - smp_base), 32'd1);
    check({tag, "_sdata"}, 32'(smp_val), 32'(adc_next));
    check({tag, "_stime"}, 32'(smp_cyc - done_cyc), 32'd1);
  endtask

  function automatic int first_wr();
    return (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1;
  endfunction

  initial begin
    bit ok;
    int used, target, f0, n_exp;
    RST_N     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (3) tick();
    check("rst_ready", 32'(req_ready), 32'hF);
    check("rst_dac_start", 32'(dac_start), 32'd0);
    check("rst_adc_start", 32'(adc_start), 32'd0);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_dac_sel", 32'(dac_sel), 32'd0);
    check("rst_dac_word", 32'(dac_word), 32'd0);
    check("rst_sample_data", 32'(sample_data), 32'd0);
    check("rst_seq_idle", 32'(seq_idle), 32'd1);
    RST_N = 1'b1;
    tick();

    // All four channels in one cycle from a fresh pointer.
    begin_round();
    for (int i = 0; i < 4; i++) code[i] = 16'($urandom);
    ser_delay = 2; ser_len = 5; adc_lat = 4; adc_next = 16'($urandom);
    drive_req(4'hF);
    model_accept(4'hF);
    model_serve(0);
    wait_sample("all4", 2000);
    check_writes("all4");
    check_conv("all4", fall_cyc, SETTLE + 1);

    // Fairness: ch0 re-requests right after being served while ch1/ch3 wait.
    wait_idle("fair");
    begin_round();
    for (int i = 0; i < 4; i++) code[i] = 16'($urandom);
    rc[0] = 16'($urandom); rc[1] = 16'($urandom);
    ser_delay = 1; ser_len = 4; adc_next = 16'($urandom);
    drive_req(4'b1011);
    model_accept(4'b1011);
    model_serve(2);
    n_exp = exp_sel_q.size();
    used = 0;
    for (int w = 0; w < n_exp; w++) begin
      ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin
        tick();
        if (dac_start) ok = 1'b1;
      end
      check($sformatf("fair_start%0d", w), 32'(ok), 32'd1);
      if (ok && dac_sel == 2'd0 && used < 2) begin
        tick();
        code[0] = rc[used];
        drive_req(4'b0001);
        used++;
      end
    end
    wait_sample("fair", 2000);
    check_writes("fair");
    check_conv("fair", fall_cyc, SETTLE + 1);

    // Single request, long busy, fixed ADC value, acceptance latency.
    wait_idle("single");
    begin_round();
    code[2] = 16'h8000;
    ser_delay = 1; ser_len = 34; adc_lat = 7; adc_next = 16'h1234;
    drive_req(4'b0100);
    check("single_ready_drop", 32'(req_ready[2]), 32'd0);
    model_accept(4'b0100);
    model_serve(0);
    wait_sample("single", 2000);
    check_writes("single");
    check("single_lat", 32'(first_wr() - acc_cyc), 32'd2);
    check_conv("single", fall_cyc, SETTLE + 1);

    // Serializer never raises busy: write completes by timeout.
    wait_idle("nobusy");
    begin_round();
    code[2] = 16'($urandom);
    ser_dead = 1'b1; adc_next = 16'($urandom);
    drive_req(4'b0100);
    model_accept(4'b0100);
    model_serve(0);
    wait_sample("nobusy", 2000);
    check_writes("nobusy");
    check_conv("nobusy", first_wr(), 1 + BTO + SETTLE);
    ser_dead = 1'b0;

    // A request at settle count 100 restarts the full settle time.
    wait_idle("resettle");
    begin_round();
    code[1] = 16'($urandom); code[2] = 16'($urandom);
    ser_delay = 1; ser_len = 6; adc_next = 16'($urandom);
    f0 = fall_cnt;
    drive_req(4'b0100);
    model_accept(4'b0100);
    model_serve(0);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      tick();
      if (fall_cnt != f0) ok = 1'b1;
    end
    check("resettle_fall", 32'(ok), 32'd1);
    target = fall_cyc + 1 + 100;
    for (int i = 0; i < 300 && cyc < target; i++) tick();
    check("resettle_reach", 32'(cyc), 32'(target));
    drive_req(4'b0010);
    model_accept(4'b0010);
    model_serve(0);
    wait_sample("resettle", 2000);
    check_writes("resettle");
    check_conv("resettle", fall_cyc, SETTLE + 1);

    // Randomized rounds.
    for (int r = 0; r < 12; r++) begin
      logic [3:0] mask;
      string tag;
      tag = $sformatf("rnd%0d", r);
      wait_idle(tag);
      begin_round();
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) code[i] = 16'($urandom);
      ser_delay = $urandom_range(0, 3);
      ser_len   = $urandom_range(2, 40);
      adc_lat   = $urandom_range(1, 30);
      adc_next  = 16'($urandom);
      drive_req(mask);
      model_accept(mask);
      model_serve(0);
      wait_sample(tag, 3000);
      check_writes(tag);
      check({tag, "_lat"}, 32'(first_wr() - acc_cyc), 32'd2);
      check_conv(tag, fall_cyc, SETTLE + 1);
    end

    // ADC never answers: conversion is abandoned after the timeout.
    wait_idle("adcto");
    begin_round();
    code[1] = 16'($urandom);
    adc_en = 1'b0;
    drive_req(4'b0010);
    model_accept(4'b0010);
    model_serve(0);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      tick();
      if (adc_cnt != adc_base) ok = 1'b1;
    end
    check("adcto_start", 32'(ok), 32'd1);
    for (int i = 0; i < ATO + 10 && cyc < adc_cyc + ATO; i++) tick();
    check("adcto_busy_last", 32'(seq_idle), 32'd0);
    tick();
    check("adcto_idle", 32'(seq_idle), 32'd1);
    check("adcto_nsmp", 32'(smp_cnt - smp_base), 32'd0);
    check_writes("adcto");
    adc_en = 1'b1;

    // Reset during ADC_WAIT; the late adc_done must not produce a sample.
    begin_round();
    code[3] = 16'($urandom) | 16'h0001;
    adc_lat = 20; adc_next = 16'($urandom);
    drive_req(4'b1000);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      tick();
      if (adc_cnt != adc_base) ok = 1'b1;
    end
    check("rstmid_start", 32'(ok), 32'd1);
    repeat (3) tick();
    RST_N = 1'b0;
    repeat (2) tick();
    m_pend = '0;
    m_ptr  = 0;
    check("rstmid_ready", 32'(req_ready), 32'hF);
    check("rstmid_dac_word", 32'(dac_word), 32'd0);
    check("rstmid_dac_sel", 32'(dac_sel), 32'd0);
    check("rstmid_sample_data", 32'(sample_data), 32'd0);
    check("rstmid_seq_idle", 32'(seq_idle), 32'd1);
    RST_N = 1'b1;
    repeat (40) tick();
    check("rstmid_nsmp", 32'(smp_cnt - smp_base), 32'd0);
    check("rstmid_nadc", 32'(adc_cnt - adc_base), 32'd1);
    check("rstmid_nwr", 32'(wr_sel_q.size()), 32'd1);
    check("rstmid_idle_after", 32'(seq_idle), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
